// File: rtl/sampler_pkg.sv
// Shared definitions for the rejection sampler: FSM state type, the
// Galois LFSR tap mask and the chunk-count helper used to size the
// candidate staging register.
package sampler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        CHECK,
        HOLD,
        FAIL
    } state_t;

    // x^32 + x^22 + x^2 + x + 1 as a right-shifting Galois tap mask
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // Number of 32-bit LFSR words needed to fill a vec_w-bit candidate
    function automatic int unsigned chunks(input int unsigned vec_w);
        return (vec_w + 32'd31) / 32'd32;
    endfunction

endpackage

// File: rtl/sampler_lfsr.sv
// 32-bit Galois LFSR (right-shifting) for candidate generation.
// Ports:
//   clk, rst_n : clock, async active-low reset (state <= SEED)
//   load, seed : synchronous load of seed (priority over step)
//   step       : advance one state
//   state      : current LFSR state
module sampler_lfsr
    import sampler_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2357
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (load) begin
            state <= seed;
        end else if (step) begin
            state <= {1'b0, state[31:1]} ^ (state[0] ? LFSR_POLY : '0);
        end
    end

endmodule

// File: rtl/rejection_sampler.sv
// Rejection sampler: builds VEC_W-bit random candidates from a 32-bit
// LFSR, presents each to an external constraint checker, and either
// hands an accepted candidate to the consumer or gives up after an
// attempt limit.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   start          : begin a run (honoured only in IDLE)
//   seed_load      : load seed_in into the LFSR (honoured only in IDLE;
//                    zero seed is replaced by 1)
//   seed_in        : seed value
//   max_attempts   : attempt limit, 0 = unlimited (captured at start)
//   cand_o         : candidate presented to the checker
//   sat_i          : checker verdict, sampled at the end of CHECK
//   sample_o       : accepted sample, valid with sample_valid
//   sample_valid   : high while holding an accepted sample
//   sample_ready   : consumer accepts the sample
//   busy           : run in progress
//   fail_o         : one-cycle pulse when the attempt limit is reached
//   attempts_o     : attempts in the current or last run (saturating)
module rejection_sampler
    import sampler_pkg::*;
#(
    parameter int unsigned VEC_W = 368,
    parameter logic [31:0] SEED  = 32'hACE1_2357
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             seed_load,
    input  logic [31:0]      seed_in,
    input  logic [15:0]      max_attempts,
    output logic [VEC_W-1:0] cand_o,
    input  logic             sat_i,
    output logic [VEC_W-1:0] sample_o,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             busy,
    output logic             fail_o,
    output logic [15:0]      attempts_o
);

    localparam int unsigned N_CHUNKS = chunks(VEC_W);
    localparam int unsigned STAGE_W  = N_CHUNKS * 32;
    localparam int unsigned CNT_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   chunk_cnt;
    logic [STAGE_W-1:0] staging;
    logic [STAGE_W-1:0] staging_shifted;
    logic [15:0]        max_r;
    logic [15:0]        attempts_inc;
    logic [31:0]        lfsr_state;
    logic [31:0]        lfsr_seed;
    logic               lfsr_load;
    logic               lfsr_step;
    logic               last_chunk;
    logic               limit_hit;

    assign lfsr_load = seed_load && (state == IDLE);
    assign lfsr_seed = (seed_in == '0) ? 32'h1 : seed_in;
    assign lfsr_step = (state == DRIVE);

    sampler_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .seed  (lfsr_seed),
        .step  (lfsr_step),
        .state (lfsr_state)
    );

    // New word enters at the top so the first word of a run ends up in
    // the least-significant chunk after N_CHUNKS shifts.
    assign staging_shifted = STAGE_W'({lfsr_state, staging} >> 32);
    assign last_chunk      = (chunk_cnt == CNT_W'(N_CHUNKS - 1));
    assign attempts_inc    = (attempts_o == 16'hFFFF) ? attempts_o : attempts_o + 16'd1;
    assign limit_hit       = (max_r != '0) && (attempts_inc == max_r);

    assign sample_valid = (state == HOLD);
    assign fail_o       = (state == FAIL);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            chunk_cnt  <= '0;
            staging    <= '0;
            cand_o     <= '0;
            sample_o   <= '0;
            attempts_o <= '0;
            max_r      <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        attempts_o <= '0;
                        max_r      <= max_attempts;
                        chunk_cnt  <= '0;
                    end
                end
                DRIVE: begin
                    staging <= staging_shifted;
                    if (last_chunk) begin
                        chunk_cnt <= '0;
                        cand_o    <= staging_shifted[VEC_W-1:0];
                    end else begin
                        chunk_cnt <= chunk_cnt + CNT_W'(1);
                    end
                end
                CHECK: begin
                    attempts_o <= attempts_inc;
                    if (sat_i) begin
                        sample_o <= cand_o;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = DRIVE;
            DRIVE:   if (last_chunk) state_nx = CHECK;
            CHECK: begin
                if (sat_i)          state_nx = HOLD;
                else if (limit_hit) state_nx = FAIL;
                else                state_nx = DRIVE;
            end
            HOLD:    if (sample_ready) state_nx = IDLE;
            FAIL:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rejection_sampler.sv
module tb_rejection_sampler;

    localparam int          VEC_W = 368;
    localparam int          CH    = (VEC_W + 31) / 32;
    localparam logic [31:0] SEED  = 32'hACE1_2357;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             seed_load;
    logic [31:0]      seed_in;
    logic [15:0]      max_attempts;
    logic [VEC_W-1:0] cand_o;
    logic             sat_i;
    logic [VEC_W-1:0] sample_o;
    logic             sample_valid;
    logic             sample_ready;
    logic             busy;
    logic             fail_o;
    logic [15:0]      attempts_o;

    rejection_sampler #(.VEC_W(VEC_W), .SEED(SEED)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .seed_load    (seed_load),
        .seed_in      (seed_in),
        .max_attempts (max_attempts),
        .cand_o       (cand_o),
        .sat_i        (sat_i),
        .sample_o     (sample_o),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .fail_o       (fail_o),
        .attempts_o   (attempts_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: LFSR value and the candidate the checker should see
    logic [31:0]      m_lfsr;
    logic [VEC_W-1:0] m_cand;

    // One LFSR step: multiplication by x^-1 modulo the feedback polynomial
    function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // Consume CH LFSR states, packing the first one in the lowest word
    function automatic logic [VEC_W-1:0] next_cand();
        logic [CH*32-1:0] w;
        for (int i = 0; i < CH; i++) begin
            w[i*32 +: 32] = m_lfsr;
            m_lfsr = lfsr_adv(m_lfsr);
        end
        return w[VEC_W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; seed_load = 1'b0; seed_in = '0;
        max_attempts = '0; sat_i = 1'b0; sample_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({busy, sample_valid, fail_o} !== 3'b000 || attempts_o !== 16'h0 ||
            cand_o !== '0 || sample_o !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy/valid/fail=%b%b%b attempts=%h, required all zero",
                     busy, sample_valid, fail_o, attempts_o);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b required 0", busy);
        end
        m_lfsr = SEED;
        m_cand = '0;
    endtask

    task automatic test_accept();
        logic [VEC_W-1:0] exp_s;
        seed_in = 32'h1; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        m_lfsr = 32'h1;
        exp_s = next_cand();
        sat_i = 1'b1; max_attempts = '0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= CH + 1; e++) begin
            if (e == CH) m_cand = exp_s;
            tick();
            n_checks++;
            if (sample_valid !== (e == CH + 1)) begin
                n_fail++;
                $display("FAIL accept_latency: edge %0d valid=%b required %b", e, sample_valid, e == CH + 1);
            end
            n_checks++;
            if (cand_o !== m_cand) begin
                n_fail++;
                $display("FAIL accept_cand: edge %0d cand_o=%h required %h", e, cand_o, m_cand);
            end
        end
        n_checks++;
        if (sample_o !== exp_s || attempts_o !== 16'd1) begin
            n_fail++;
            $display("FAIL accept_sample: sample=%h attempts=%0d required %h / 1", sample_o, attempts_o, exp_s);
        end
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || sample_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_release: busy=%b valid=%b required 0 0", busy, sample_valid);
        end
    endtask

    task automatic test_fail_limit();
        int pulses = 0;
        int fail_edge = -1;
        int valid_seen = 0;
        logic [15:0] att_at_fail = '0;
        sat_i = 1'b0; max_attempts = 16'd3; start = 1'b1;
        tick();
        start = 1'b0; max_attempts = '0;
        for (int e = 1; e <= 60; e++) begin
            tick();
            if (fail_o) begin
                pulses++;
                if (fail_edge < 0) begin
                    fail_edge = e;
                    att_at_fail = attempts_o;
                end
            end
            if (sample_valid) valid_seen++;
        end
        for (int k = 0; k < 3; k++) m_cand = next_cand();
        n_checks++;
        if (pulses != 1 || fail_edge != 3 * (CH + 1)) begin
            n_fail++;
            $display("FAIL fail_pulse: pulses=%0d edge=%0d required 1 at %0d", pulses, fail_edge, 3 * (CH + 1));
        end
        n_checks++;
        if (att_at_fail !== 16'd3 || valid_seen != 0) begin
            n_fail++;
            $display("FAIL fail_attempts: attempts=%0d valid_cycles=%0d required 3 / 0", att_at_fail, valid_seen);
        end
        n_checks++;
        if (busy !== 1'b0 || cand_o !== m_cand) begin
            n_fail++;
            $display("FAIL fail_idle: busy=%b cand=%h required 0 / %h", busy, cand_o, m_cand);
        end
    endtask

    task automatic test_hold();
        logic [VEC_W-1:0] exp_s;
        exp_s = next_cand();
        m_cand = exp_s;
        sat_i = 1'b1; sample_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (CH + 1) tick();
        for (int i = 0; i < 10; i++) begin
            sat_i = 1'($urandom_range(0, 1));
            n_checks++;
            if (sample_valid !== 1'b1 || sample_o !== exp_s) begin
                n_fail++;
                $display("FAIL hold_stable: cycle %0d valid=%b sample=%h required 1 / %h", i, sample_valid, sample_o, exp_s);
            end
            tick();
        end
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || sample_valid !== 1'b0 || attempts_o !== 16'd1) begin
            n_fail++;
            $display("FAIL hold_release: busy=%b valid=%b attempts=%0d required 0 0 1", busy, sample_valid, attempts_o);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [VEC_W-1:0] exp_s;
        int pulses = 0;
        sat_i = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, sample_valid, fail_o} !== 3'b000 || attempts_o !== 16'h0 ||
            cand_o !== '0 || sample_o !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: busy/valid/fail=%b%b%b attempts=%h, required all zero",
                     busy, sample_valid, fail_o, attempts_o);
        end
        m_lfsr = SEED;
        m_cand = '0;
        #2 rst_n = 1'b1;
        for (int e = 0; e < 30; e++) begin
            tick();
            if (fail_o || sample_valid || busy) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL midrun_quiet: %0d active cycles after release, required 0", pulses);
        end
        exp_s = next_cand();
        m_cand = exp_s;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (CH + 1) tick();
        n_checks++;
        if (sample_valid !== 1'b1 || sample_o !== exp_s) begin
            n_fail++;
            $display("FAIL midrun_seed: valid=%b sample=%h required 1 / %h (LFSR from SEED)", sample_valid, sample_o, exp_s);
        end
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
    endtask

    task automatic test_seed_zero();
        logic [VEC_W-1:0] exp_s;
        m_lfsr = 32'h1;
        exp_s = next_cand();
        m_cand = exp_s;
        seed_in = '0; seed_load = 1'b1; start = 1'b1; sat_i = 1'b1;
        tick();
        seed_load = 1'b0; start = 1'b0;
        repeat (CH + 1) tick();
        n_checks++;
        if (sample_valid !== 1'b1 || sample_o !== exp_s || attempts_o !== 16'd1) begin
            n_fail++;
            $display("FAIL seed_zero: valid=%b sample=%h attempts=%0d required 1 / %h / 1",
                     sample_valid, sample_o, attempts_o, exp_s);
        end
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
    endtask

    // Random runs; start, seed_load, seed_in and max_attempts are also
    // randomised while busy, where the model says they must be ignored.
    task automatic test_random(input int runs);
        for (int r = 0; r < runs; r++) begin
            logic [VEC_W-1:0] cand_this;
            logic [31:0] s;
            logic        sat_s;
            int mode, mx, att, e_in, phase, hn;
            mode = $urandom_range(0, 2);
            s = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            seed_in = s;
            if (mode == 1) begin
                seed_load = 1'b1;
                tick();
                seed_load = 1'b0;
            end
            if (mode != 0) m_lfsr = (s == 0) ? 32'h1 : s;
            seed_load = (mode == 2);
            mx = $urandom_range(0, 4);
            max_attempts = 16'(mx);
            start = 1'b1;
            tick();
            start = 1'b0; seed_load = 1'b0;
            att = 0; e_in = 0; phase = 0;
            cand_this = next_cand();
            for (int e = 0; e < 400 && phase == 0; e++) begin
                sat_i = (att >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
                start = 1'($urandom_range(0, 1));
                seed_load = 1'($urandom_range(0, 1));
                seed_in = $urandom;
                max_attempts = 16'($urandom);
                sat_s = sat_i;
                tick();
                e_in++;
                if (e_in == CH) m_cand = cand_this;
                if (e_in == CH + 1) begin
                    e_in = 0;
                    att++;
                    if (sat_s) phase = 1;
                    else if (mx != 0 && att == mx) phase = 2;
                    else cand_this = next_cand();
                end
                n_checks++;
                if (busy !== 1'b1 || sample_valid !== (phase == 1) || fail_o !== (phase == 2) ||
                    attempts_o !== 16'(att) || cand_o !== m_cand) begin
                    n_fail++;
                    $display("FAIL random_step: run %0d edge %0d busy=%b valid=%b fail=%b attempts=%0d cand=%h required 1 %b %b %0d %h",
                             r, e, busy, sample_valid, fail_o, attempts_o, cand_o, phase == 1, phase == 2, att, m_cand);
                end
            end
            start = 1'b0; seed_load = 1'b0; sat_i = 1'b0;
            n_checks++;
            if (phase == 0) begin
                n_fail++;
                $display("FAIL random_timeout: run %0d never finished, attempts=%0d", r, attempts_o);
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
                m_lfsr = SEED;
                m_cand = '0;
            end else if (phase == 1) begin
                hn = $urandom_range(0, 3);
                for (int i = 0; i < hn; i++) begin
                    start = 1'($urandom_range(0, 1));
                    seed_load = 1'($urandom_range(0, 1));
                    seed_in = $urandom;
                    tick();
                end
                start = 1'b0; seed_load = 1'b0;
                if (sample_valid !== 1'b1 || sample_o !== m_cand) begin
                    n_fail++;
                    $display("FAIL random_sample: run %0d valid=%b sample=%h required 1 / %h", r, sample_valid, sample_o, m_cand);
                end
                sample_ready = 1'b1;
                tick();
                sample_ready = 1'b0;
            end else begin
                tick();
                if (busy !== 1'b0 || fail_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL random_fail_end: run %0d busy=%b fail=%b required 0 0", r, busy, fail_o);
                end
            end
            n_checks++;
            if (busy !== 1'b0 || sample_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL random_idle: run %0d busy=%b valid=%b required 0 0", r, busy, sample_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_accept();
        test_fail_limit();
        test_hold();
        test_reset_mid_run();
        test_seed_zero();
        test_random(20);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rejection_sampler.md
REJECTION_SAMPLER -- requirements
Module: rejection_sampler

Interface
REQ-001 Parameter VEC_W, default 368, SHALL be the width of the packed candidate vector driven to the constraint checker.
REQ-002 Parameter SEED, default 32'hACE1_2357, SHALL be the nonzero LFSR reset value.
REQ-003 Clock and reset SHALL be: one clock `clk`; reset `rst_n`, asynchronous and active-low.
REQ-004 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  begin a sampling run
- seed_load  in  1  load seed_in into LFSR
- seed_in  in  32  seed value
- max_attempts  in  16  attempt limit; 0 = unlimited
- cand_o  out  VEC_W  candidate to checker
- sat_i  in  1  checker verdict (checker output x)
- sample_o  out  VEC_W  accepted sample
- sample_valid  out  1  sample_o valid
- sample_ready  in  1  consumer accepts
- busy  out  1  run in progress
- fail_o  out  1  one-cycle pulse: limit reached
- attempts_o  out  16  attempts in current/last run

Function
REQ-005 LFSR SHALL be 32-bit Galois, polynomial x^32+x^22+x^2+x+1, advancing once per DRIVE cycle only.
REQ-006 CHUNKS = ceil(VEC_W/32) SHALL be the DRIVE length; each DRIVE cycle shifts one LFSR state into a staging register, LSB chunk first.
REQ-007 cand_o SHALL update atomically on the last DRIVE cycle's edge (low VEC_W staging bits); it SHALL hold otherwise.
REQ-008 FSM states SHALL be IDLE, DRIVE, CHECK, HOLD, FAIL.
REQ-009 IDLE: start=1 SHALL go to DRIVE, clear attempts_o; start outside IDLE SHALL be ignored.
REQ-010 CHECK SHALL last exactly one cycle; sat_i SHALL be sampled only at its closing edge.
REQ-011 sat_i=1 in CHECK SHALL copy cand_o to sample_o, increment attempts_o, go to HOLD.
REQ-012 sat_i=0 in CHECK SHALL increment attempts_o; if max_attempts!=0 and new count==max_attempts go to FAIL, else DRIVE.
REQ-013 attempts_o SHALL saturate at 16'hFFFF; with max_attempts=0 the run continues past saturation.
REQ-014 sample_valid SHALL be high exactly in HOLD; sample_o stable while valid; transfer on sample_valid&&sample_ready returns to IDLE.
REQ-015 FAIL SHALL last one cycle, assert fail_o only then, go to IDLE.
REQ-016 busy SHALL be high in DRIVE, CHECK, HOLD, FAIL.
REQ-017 Latency: start at edge 0 with sat_i=1 SHALL give sample_valid visible from cycle CHUNKS+2 (14 for default).
REQ-018 seed_load SHALL take effect only in IDLE (ignored otherwise); seed_in=0 SHALL load 32'h1; seed_load and start together: seed loads first, run uses it.
REQ-019 max_attempts SHALL be sampled on the start edge and held for the run.

Reset
REQ-020 rst_n low SHALL asynchronously force IDLE, LFSR=SEED, cand_o, sample_o, staging, attempts_o = 0, sample_valid, busy, fail_o = 0.
REQ-021 Reset mid-run SHALL abandon the run with no fail_o or sample_valid pulse after release.

Structure
REQ-022 Package sampler_pkg SHALL hold the state enum, LFSR polynomial constant (32'h8020_0003 tap mask), and a chunks(VEC_W) function.
REQ-023 LFSR SHALL be sub-module sampler_lfsr (ports clk, rst_n, load, seed, step, state).

Verification
REQ-024 sat_i tied 1, seed_in=32'h1 loaded, start -> sample_valid at cycle 14, attempts_o=1, sample_o equals 12 LFSR states from seed 1 (low 368 bits).
REQ-025 sat_i tied 0, max_attempts=3, start -> fail_o single pulse at cycle 3*13+1=40, attempts_o=3, no sample_valid.
REQ-026 sat_i=1 with sample_ready low 10 cycles -> sample_o, sample_valid stable throughout; IDLE on cycle after ready rises.
REQ-027 rst_n low during DRIVE cycle 5 -> all outputs zero immediately, LFSR=SEED, no pulse after release.
REQ-028 seed_in=0 with seed_load -> LFSR=32'h1; start while busy -> no effect on attempts_o or state sequence.
